// File: rtl/toggle_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : toggle_monitor
//  Purpose  : Synchronizes an asynchronous toggle input, measures the interval
//             between transitions and reports tolerance, lock and timeout.
//  Revision : 1.0 - initial release
// ============================================================================
module toggle_monitor #(
    parameter int CNT_W    = 17,
    parameter int EXPECTED = 601,
    parameter int TOL      = 2,
    parameter int LOCK_N   = 4,
    parameter int TIMEOUT  = 1202
) (
    input  logic             clk100,
    input  logic             rst_n,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period_o,
    output logic             period_valid,
    output logic             in_tol,
    output logic             locked,
    output logic             timeout_o,
    output logic [7:0]       err_count
);

    localparam int               GOOD_W    = $clog2(LOCK_N + 1);
    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W:0]   C_EXP     = (CNT_W + 1)'(EXPECTED);
    localparam logic [CNT_W:0]   C_TOL     = (CNT_W + 1)'(TOL);
    localparam logic [GOOD_W-1:0] C_LOCK_N = GOOD_W'(LOCK_N);

    typedef enum logic [1:0] {
        SEEK   = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                s1_q, s2_q, s3_q;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [GOOD_W-1:0]   good_q, good_d;
    logic [CNT_W-1:0]    period_q, period_d;
    logic                pv_q, pv_d;
    logic                tol_q, tol_d;
    logic                locked_q, locked_d;
    logic                to_q, to_d;
    logic [7:0]          err_q, err_d;

    logic                edge_w;
    logic                timeout_hit_w;
    logic                tol_ok_w;
    logic                err_inc_w;
    logic [CNT_W:0]      interval_w;
    logic [CNT_W:0]      diff_w;
    logic [CNT_W-1:0]    interval_sat_w;

    // Interval and deviation are computed one bit wider so neither can wrap.
    always_comb begin
        edge_w         = s2_q ^ s3_q;
        interval_w     = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
        diff_w         = (interval_w >= C_EXP) ? (interval_w - C_EXP) : (C_EXP - interval_w);
        tol_ok_w       = (diff_w <= C_TOL);
        interval_sat_w = interval_w[CNT_W] ? C_CNT_MAX : interval_w[CNT_W-1:0];
        timeout_hit_w  = !edge_w && (cnt_q == C_TIMEOUT);
    end

    always_comb begin
        state_d   = state_q;
        good_d    = good_q;
        period_d  = period_q;
        pv_d      = 1'b0;
        tol_d     = tol_q;
        to_d      = to_q;
        err_inc_w = 1'b0;

        if (edge_w)
            cnt_d = '0;
        else if (cnt_q == C_CNT_MAX)
            cnt_d = cnt_q;
        else
            cnt_d = cnt_q + 1'b1;

        if (edge_w) begin
            to_d = 1'b0;
            case (state_q)
                SEEK: begin
                    state_d = TRACK;
                    good_d  = '0;
                end
                TRACK, LOCKED: begin
                    pv_d     = 1'b1;
                    period_d = interval_sat_w;
                    tol_d    = tol_ok_w;
                    if (tol_ok_w) begin
                        if (state_q == TRACK) begin
                            good_d = good_q + 1'b1;
                            if (good_q + 1'b1 == C_LOCK_N)
                                state_d = LOCKED;
                        end
                    end else begin
                        good_d    = '0;
                        err_inc_w = 1'b1;
                        state_d   = TRACK;
                    end
                end
                default: state_d = SEEK;
            endcase
        end else if (timeout_hit_w) begin
            to_d = 1'b1;
            if (state_q != SEEK) begin
                err_inc_w = 1'b1;
                state_d   = SEEK;
            end
        end

        err_d    = (err_inc_w && (err_q != 8'hFF)) ? err_q + 8'd1 : err_q;
        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            s3_q     <= 1'b0;
            state_q  <= SEEK;
            cnt_q    <= '0;
            good_q   <= '0;
            period_q <= '0;
            pv_q     <= 1'b0;
            tol_q    <= 1'b0;
            locked_q <= 1'b0;
            to_q     <= 1'b0;
            err_q    <= 8'd0;
        end else begin
            s1_q     <= sig_in;
            s2_q     <= s1_q;
            s3_q     <= s2_q;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            good_q   <= good_d;
            period_q <= period_d;
            pv_q     <= pv_d;
            tol_q    <= tol_d;
            locked_q <= locked_d;
            to_q     <= to_d;
            err_q    <= err_d;
        end
    end

    assign period_o     = period_q;
    assign period_valid = pv_q;
    assign in_tol       = tol_q;
    assign locked       = locked_q;
    assign timeout_o    = to_q;
    assign err_count    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_toggle_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_toggle_monitor
//  Purpose  : Directed and randomized self-checking bench for toggle_monitor.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_toggle_monitor;

    localparam int CNT_W    = 17;
    localparam int EXPECTED = 601;
    localparam int TOL      = 2;
    localparam int LOCK_N   = 4;
    localparam int TIMEOUT  = 1202;

    logic             clk100 = 1'b0;
    logic             rst_n  = 1'b0;
    logic             sig_in = 1'b0;
    logic [CNT_W-1:0] period_o;
    logic             period_valid, in_tol, locked, timeout_o;
    logic [7:0]       err_count;

    // Small instance used to exercise interval-counter saturation quickly.
    logic             sig_s = 1'b0;
    logic [7:0]       period_s;
    logic             pv_s, tol_s, locked_s, to_s;
    logic [7:0]       err_s;

    toggle_monitor #(
        .CNT_W(CNT_W), .EXPECTED(EXPECTED), .TOL(TOL), .LOCK_N(LOCK_N), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk100(clk100), .rst_n(rst_n), .sig_in(sig_in),
        .period_o(period_o), .period_valid(period_valid), .in_tol(in_tol),
        .locked(locked), .timeout_o(timeout_o), .err_count(err_count)
    );

    toggle_monitor #(
        .CNT_W(8), .EXPECTED(20), .TOL(2), .LOCK_N(4), .TIMEOUT(100)
    ) dut_s (
        .clk100(clk100), .rst_n(rst_n), .sig_in(sig_s),
        .period_o(period_s), .period_valid(pv_s), .in_tol(tol_s),
        .locked(locked_s), .timeout_o(to_s), .err_count(err_s)
    );

    always #5 clk100 = ~clk100;

    int cyc = 0;
    always @(posedge clk100) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: behaviour expressed over whole toggle intervals.
    bit m_armed  = 1'b0;
    bit m_locked = 1'b0;
    int m_good   = 0;
    int m_errs   = 0;
    int last_tgl = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic bump_err();
        if (m_errs < 255) m_errs++;
    endtask

    task automatic wait_cyc(input int m);
        repeat (m) @(negedge clk100);
    endtask

    // Called on a negedge; the edge reaches the outputs 3 posedges later.
    task automatic edge_step(input bit do_toggle, input string tag);
        int  interval;
        int  dev;
        bit  exp_pv;
        bit  exp_tol;
        if (do_toggle) sig_in = ~sig_in;
        interval = cyc - last_tgl;
        last_tgl = cyc;
        if (m_armed && interval > TIMEOUT + 1) begin
            m_armed = 1'b0; m_locked = 1'b0; m_good = 0; bump_err();
        end
        exp_pv  = 1'b0;
        exp_tol = 1'b0;
        if (!m_armed) begin
            m_armed = 1'b1;
            m_good  = 0;
        end else begin
            exp_pv  = 1'b1;
            dev     = interval - EXPECTED;
            if (dev < 0) dev = -dev;
            exp_tol = (dev <= TOL);
            if (exp_tol) begin
                if (!m_locked) begin
                    m_good++;
                    if (m_good >= LOCK_N) m_locked = 1'b1;
                end
            end else begin
                m_good = 0; m_locked = 1'b0; bump_err();
            end
        end
        repeat (3) @(posedge clk100);
        @(negedge clk100);
        check({tag, ".pv"}, 32'(period_valid), 32'(exp_pv));
        if (exp_pv) begin
            check({tag, ".period"}, 32'(period_o), interval);
            check({tag, ".in_tol"}, 32'(in_tol), 32'(exp_tol));
        end
        check({tag, ".locked"}, 32'(locked), 32'(m_locked));
        check({tag, ".err"}, 32'(err_count), m_errs);
        check({tag, ".timeout"}, 32'(timeout_o), 0);
        @(negedge clk100);
        check({tag, ".pv_next"}, 32'(period_valid), 0);
    endtask

    task automatic step(input int n, input string tag);
        edge_step(1'b1, tag);
        wait_cyc(n - 4);
    endtask

    initial begin
        int r;
        // Reset state
        wait_cyc(3);
        check("rst.period", 32'(period_o), 0);
        check("rst.pv", 32'(period_valid), 0);
        check("rst.in_tol", 32'(in_tol), 0);
        check("rst.locked", 32'(locked), 0);
        check("rst.timeout", 32'(timeout_o), 0);
        check("rst.err", 32'(err_count), 0);
        rst_n    = 1'b1;
        last_tgl = cyc;
        wait_cyc(10);

        for (int i = 0; i < 6; i++) step(601, "nominal");
        for (int i = 0; i < 6; i++) step((i % 2) ? 603 : 599, "jitter");
        step(604, "oot");
        for (int i = 0; i < 6; i++) step(601, "relock");

        // Signal lost while locked
        edge_step(1'b1, "lost_last");
        wait_cyc(1201);
        check("lost.timeout_before", 32'(timeout_o), 0);
        check("lost.locked_before", 32'(locked), 1);
        wait_cyc(1);
        check("lost.timeout", 32'(timeout_o), 1);
        check("lost.locked", 32'(locked), 0);
        check("lost.err", 32'(err_count), m_errs + 1);
        wait_cyc(200);
        check("lost.timeout_hold", 32'(timeout_o), 1);
        for (int i = 0; i < 6; i++) step(601, "rearm");
        step(590, "oot2");
        for (int i = 0; i < 6; i++) step(601, "relock2");

        // Asynchronous reset mid-lock
        wait_cyc(50);
        check("prerst.err", 32'(err_count), 3);
        check("prerst.locked", 32'(locked), 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst.period", 32'(period_o), 0);
        check("arst.in_tol", 32'(in_tol), 0);
        check("arst.locked", 32'(locked), 0);
        check("arst.err", 32'(err_count), 0);
        check("arst.timeout", 32'(timeout_o), 0);
        wait_cyc(3);
        rst_n    = 1'b1;
        m_armed  = 1'b0; m_locked = 1'b0; m_good = 0; m_errs = 0;
        last_tgl = cyc;
        edge_step(!sig_in, "rearm_rst");
        wait_cyc(597);
        for (int i = 0; i < 5; i++) step(601, "lock_rst");

        // Error counter saturation with short intervals
        for (int i = 0; i < 260; i++) step($urandom_range(5, 40), "sat");
        check("sat.err", 32'(err_count), 255);

        // Randomized intervals around the nominal half-period
        for (int i = 0; i < 24; i++) begin
            r = $urandom_range(0, 9);
            step((r < 7) ? $urandom_range(599, 603) : $urandom_range(560, 640), "rand");
        end

        // Interval counter saturation on the narrow instance
        sig_s = 1'b1;
        wait_cyc(5);
        check("s.arm_err", 32'(err_s), 0);
        check("s.arm_to", 32'(to_s), 0);
        wait_cyc(400);
        check("s.to", 32'(to_s), 1);
        check("s.err", 32'(err_s), 1);
        check("s.cnt_sat", 32'(dut_s.cnt_q), 255);
        wait_cyc(300);
        check("s.to_hold", 32'(to_s), 1);
        check("s.err_hold", 32'(err_s), 1);
        sig_s = 1'b0;
        repeat (3) @(posedge clk100);
        @(negedge clk100);
        check("s.clr_to", 32'(to_s), 0);
        check("s.clr_pv", 32'(pv_s), 0);
        check("s.locked", 32'(locked_s), 0);
        check("s.misc", 32'({period_s, tol_s}), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
